// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states, mux selects.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

  // Opcodes recognised by the controller (instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FSM state encoding; the value is exported on the debug state port
  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;

  // result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
// Latency: n/a (wires only). Optional macro MEM_WAIT_EN adds the mem_ready handshake.
// Backpressure: with MEM_WAIT_EN, mem_ready=0 stalls the memory states; otherwise none.
interface multicycle_controller_if #(
  parameter int OPC_W = 7,
  parameter int ST_W  = 4
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
`ifdef MEM_WAIT_EN
  logic             mem_ready;
`endif
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             illegal_instr;
  logic [ST_W-1:0]  state;

`ifdef MEM_WAIT_EN
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, state
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, state
  );
`else
  modport master (
    input  opcode, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, state
  );
  modport slave (
    output opcode, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, state
  );
`endif

endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-format decode, shared with the single-cycle core.
// Latency: purely combinational.
// Backpressure: none.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // stores, branches and jal carry their own immediate layouts; everything else is I-type
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multi-cycle RV32I core (lw, sw, R, I-ALU, beq, jal); optional macro MEM_WAIT_EN.
// Latency: 3-5 cycles per instruction (beq 3, sw/R/I/jal 4, lw 5) plus memory waits.
// Backpressure: with MEM_WAIT_EN, FETCH/MEMREAD/MEMWRITE hold until mem_ready=1.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master ctl
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_ok;
  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal_instr;

`ifdef MEM_WAIT_EN
  assign mem_ok = ctl.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // state register; reset drops every write enable without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // next-state: opcode is only consulted from DECODE onward, once the IR is stable
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctl.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_INIT;
    endcase
  end

  // per-state datapath controls; unlisted controls stay 0
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC while the IR latches
        ir_write   = mem_ok;
        pc_update  = mem_ok;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        // branch target precomputed into ALUOut for a possible beq
        alu_src_a     = SRCA_OLDPC;
        alu_src_b     = SRCB_IMM;
        alu_op        = ALUOP_ADD;
        illegal_instr = ~is_supported(ctl.opcode);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      S_JAL: begin
        // ALU forms OldPC+4 as the link value while ALUOut (target) loads the PC
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  imm_src_decoder u_imm_src_decoder (
    .opcode  (ctl.opcode),
    .imm_src (imm_src)
  );

  assign ctl.pc_write      = pc_update | (branch & ctl.zero);
  assign ctl.adr_src       = adr_src;
  assign ctl.mem_write     = mem_write;
  assign ctl.ir_write      = ir_write;
  assign ctl.reg_write     = reg_write;
  assign ctl.result_src    = result_src;
  assign ctl.alu_src_a     = alu_src_a;
  assign ctl.alu_src_b     = alu_src_b;
  assign ctl.alu_op        = alu_op;
  assign ctl.imm_src       = imm_src;
  assign ctl.illegal_instr = illegal_instr;
  assign ctl.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a random instruction stream.
// Latency: n/a (simulation only). Exercises MEM_WAIT_EN scenarios when that macro is defined.
// Backpressure: mem_ready held at 1 except inside the wait-state scenario.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cycles;
        int         rw;
        int         mw;
        int         pw;
        int         ill;
        int         adr;
        logic [1:0] imm;
    } expect_t;

    // Instruction-level reference: what one instruction should produce in total
    function automatic expect_t model(input logic [6:0] op, input bit z);
        expect_t e;
        e.cycles = 2; e.rw = 0; e.mw = 0; e.pw = 1; e.ill = 1; e.adr = 0; e.imm = 2'b00;
        case (op)
            7'b0000011: begin e.cycles = 5; e.rw = 1; e.ill = 0; e.adr = 1; end
            7'b0100011: begin e.cycles = 4; e.mw = 1; e.ill = 0; e.adr = 1; e.imm = 2'b01; end
            7'b0110011,
            7'b0010011: begin e.cycles = 4; e.rw = 1; e.ill = 0; end
            7'b1100011: begin e.cycles = 3; e.pw = 1 + int'(z); e.ill = 0; e.imm = 2'b10; end
            7'b1101111: begin e.cycles = 4; e.rw = 1; e.pw = 2; e.ill = 0; e.imm = 2'b11; end
            default:    e.cycles = 2;
        endcase
        return e;
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [15:0] all_outs();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src,
                bus.illegal_instr};
    endfunction

    // advance to the sample point of the next cycle (just after the falling edge)
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 7'b0000000;
        bus.zero = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.state !== 4'd0 || all_outs() !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: state=%0d outs=%h, want state=0 outs=0", i, bus.state, all_outs());
            end
            if (i < 2) step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || all_outs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_release: state=%0d outs=%h, want state=0 outs=0", bus.state, all_outs());
        end
        step();
        checks++;
        if (bus.state !== 4'd1 || bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1 || bus.alu_src_b !== 2'b10) begin
            errors++;
            $display("FAIL first_fetch: state=%0d ir_write=%b pc_write=%b alu_src_b=%b, want 1/1/1/10",
                     bus.state, bus.ir_write, bus.pc_write, bus.alu_src_b);
        end
    endtask

    task automatic test_lw();
        int exp_st[5] = '{1, 2, 3, 4, 5};
        bus.opcode = 7'b0000011;
        bus.zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++;
                $display("FAIL lw_state cyc%0d: got %0d, want %0d", i, bus.state, exp_st[i]);
            end
            checks++;
            if (bus.reg_write !== 1'(i == 4)) begin
                errors++;
                $display("FAIL lw_reg_write cyc%0d: got %b, want %b", i, bus.reg_write, i == 4);
            end
            if (i == 4) begin
                checks++;
                if (bus.result_src !== 2'b01) begin
                    errors++;
                    $display("FAIL lw_result_src: got %b, want 01", bus.result_src);
                end
            end
        end
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL lw_return: state=%0d, want 1", bus.state);
        end
    endtask

    task automatic test_sw();
        int exp_st[4] = '{1, 2, 3, 6};
        bus.opcode = 7'b0100011;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.state !== 4'(exp_st[i]) || bus.mem_write !== 1'(i == 3) || bus.adr_src !== 1'(i == 3)
                || bus.imm_src !== 2'b01) begin
                errors++;
                $display("FAIL sw cyc%0d: state=%0d mem_write=%b adr_src=%b imm_src=%b, want %0d/%b/%b/01",
                         i, bus.state, bus.mem_write, bus.adr_src, bus.imm_src, exp_st[i], i == 3, i == 3);
            end
        end
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL sw_return: state=%0d, want 1", bus.state);
        end
    endtask

    task automatic test_beq(input bit z);
        int exp_st[3] = '{1, 2, 10};
        bus.opcode = 7'b1100011;
        bus.zero = z;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.state !== 4'(exp_st[i]) || bus.imm_src !== 2'b10) begin
                errors++;
                $display("FAIL beq_z%0d cyc%0d: state=%0d imm_src=%b, want %0d/10", z, i, bus.state, bus.imm_src, exp_st[i]);
            end
        end
        checks++;
        if (bus.pc_write !== z) begin
            errors++;
            $display("FAIL beq_pc_write_z%0d: got %b, want %b", z, bus.pc_write, z);
        end
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL beq_return_z%0d: state=%0d, want 1", z, bus.state);
        end
    endtask

    task automatic test_illegal();
        bus.opcode = 7'b1111111;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.state !== 4'(i + 1) || bus.illegal_instr !== 1'(i == 1)
                || bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0) begin
                errors++;
                $display("FAIL illegal cyc%0d: state=%0d illegal=%b rw=%b mw=%b, want %0d/%b/0/0",
                         i, bus.state, bus.illegal_instr, bus.reg_write, bus.mem_write, i + 1, i == 1);
            end
        end
        step();
        checks++;
        if (bus.state !== 4'd1 || bus.illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_return: state=%0d illegal=%b, want 1/0", bus.state, bus.illegal_instr);
        end
    endtask

    task automatic test_mid_reset();
        bus.opcode = 7'b0100011;
        #1;
        step(); step(); step();
        checks++;
        if (bus.state !== 4'd6 || bus.mem_write !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: state=%0d mem_write=%b, want 6/1", bus.state, bus.mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || bus.adr_src !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: state=%0d mem_write=%b adr_src=%b, want 0/0/0",
                     bus.state, bus.mem_write, bus.adr_src);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL midrst_recover: state=%0d, want 1", bus.state);
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        int mw_cycles;
        // FETCH stalls with no IR/PC update while memory is busy
        bus.mem_ready = 1'b0;
        bus.opcode = 7'b0100011;
        #1;
        checks++;
        if (bus.state !== 4'd1 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: state=%0d ir_write=%b pc_write=%b, want 1/0/0", bus.state, bus.ir_write, bus.pc_write);
        end
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL fetch_hold: state=%0d, want 1", bus.state);
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ready: ir_write=%b pc_write=%b, want 1/1", bus.ir_write, bus.pc_write);
        end
        step(); step();
        bus.mem_ready = 1'b0;
        mw_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin bus.mem_ready = 1'b1; #1; end
            checks++;
            if (bus.state !== 4'd6) begin
                errors++;
                $display("FAIL memwrite_hold cyc%0d: state=%0d, want 6", i, bus.state);
            end
            if (bus.mem_write === 1'b1) mw_cycles++;
        end
        checks++;
        if (mw_cycles !== 4) begin
            errors++;
            $display("FAIL memwrite_len: got %0d cycles, want 4", mw_cycles);
        end
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL memwrite_exit: state=%0d, want 1", bus.state);
        end
        // lw stalled in MEMREAD, then reset mid-wait
        bus.opcode = 7'b0000011;
        step(); step();
        bus.mem_ready = 1'b0;
        step(); step();
        checks++;
        if (bus.state !== 4'd4) begin
            errors++;
            $display("FAIL memread_hold: state=%0d, want 4", bus.state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL memread_reset: state=%0d, want 0", bus.state);
        end
        step();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL memread_recover: state=%0d, want 1", bus.state);
        end
    endtask
`endif

    // one instruction from FETCH back to FETCH, checked against instruction-level totals
    task automatic run_instr(input logic [6:0] op, input bit z, input int idx);
        expect_t e;
        int cyc, rw, mw, pw, ill, adr, irw;
        bit imm_bad;
        e = model(op, z);
        cyc = 0; rw = 0; mw = 0; pw = 0; ill = 0; adr = 0; irw = 0; imm_bad = 1'b0;
        bus.opcode = op;
        bus.zero = z;
        #1;
        forever begin
            cyc++;
            if (bus.reg_write === 1'b1) rw++;
            if (bus.mem_write === 1'b1) mw++;
            if (bus.pc_write === 1'b1) pw++;
            if (bus.illegal_instr === 1'b1) ill++;
            if (bus.adr_src === 1'b1) adr++;
            if (bus.ir_write === 1'b1) irw++;
            if (bus.imm_src !== e.imm) imm_bad = 1'b1;
            step();
            if (bus.state === 4'd1 || cyc >= 20) break;
        end
        checks++;
        if (cyc !== e.cycles) begin
            errors++;
            $display("FAIL rnd%0d op=%b cycles: got %0d, want %0d", idx, op, cyc, e.cycles);
        end
        checks++;
        if (rw !== e.rw) begin
            errors++;
            $display("FAIL rnd%0d op=%b reg_write: got %0d, want %0d", idx, op, rw, e.rw);
        end
        checks++;
        if (mw !== e.mw) begin
            errors++;
            $display("FAIL rnd%0d op=%b mem_write: got %0d, want %0d", idx, op, mw, e.mw);
        end
        checks++;
        if (pw !== e.pw) begin
            errors++;
            $display("FAIL rnd%0d op=%b z=%0d pc_write: got %0d, want %0d", idx, op, z, pw, e.pw);
        end
        checks++;
        if (ill !== e.ill) begin
            errors++;
            $display("FAIL rnd%0d op=%b illegal: got %0d, want %0d", idx, op, ill, e.ill);
        end
        checks++;
        if (adr !== e.adr) begin
            errors++;
            $display("FAIL rnd%0d op=%b adr_src: got %0d, want %0d", idx, op, adr, e.adr);
        end
        checks++;
        if (irw !== 1) begin
            errors++;
            $display("FAIL rnd%0d op=%b ir_write: got %0d, want 1", idx, op, irw);
        end
        checks++;
        if (imm_bad) begin
            errors++;
            $display("FAIL rnd%0d op=%b imm_src: got %b, want %b", idx, op, bus.imm_src, e.imm);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        logic [6:0] op;
        int sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 6);
            if (sel < 6) op = ops[sel];
            else begin
                op = 7'($urandom_range(0, 127));
                while (legal_op(op)) op = 7'($urandom_range(0, 127));
            end
            run_instr(op, 1'($urandom_range(0, 1)), n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_mid_reset();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
